pll_lock_supervisor: RTL and testbench
======================================

Name: pll_lock_supervisor

Overview:
Reset and lock sequencer for the UART baud-clock PLL (50 MHz refclk in, 1.8432 MHz out). Drives the PLL reset and watches its asynchronous locked output. Holds the downstream serial-port logic in reset until lock has been continuously stable, and retries a bounded number of times before flagging a fault. Sits between the board reset and the PLL instance, clocked on the PLL reference clock.

Parameters:
RST_PULSE_CYCLES, 16, cycles pll_rst is held high per PLL reset attempt (>=1)
LOCK_TIMEOUT, 50000, cycles allowed in WAIT_LOCK before an attempt fails (1 ms @ 50 MHz)
LOCK_STABLE_CYCLES, 1024, consecutive synced-lock cycles required before release
MAX_RETRIES, 3, failed attempts tolerated before FAULT
CNT_W, 20, width of the shared cycle counter; must hold max(all cycle parameters)-1
RETRY_W, 2, width of retry_cnt; must hold MAX_RETRIES

Ports:
refclk  input  1  50 MHz reference clock, sole clock
rst  input  1  synchronous, active-high reset
pll_locked  input  1  PLL locked, asynchronous to refclk
clear_fault  input  1  single-cycle request to leave FAULT
pll_rst  output  1  reset to the PLL, active-high
sys_rst  output  1  reset to downstream logic, active-high
ready  output  1  high only in RUN
fault  output  1  high only in FAULT
retry_cnt  output  RETRY_W  failed attempts since the last RUN or clear

Behaviour:
- Interface: one clock, refclk; reset rst is synchronous and active-high.
- Reset: state=PLL_RST, counter=0, retry_cnt=0, both synchronizer flops=0, pll_rst=1, sys_rst=1, ready=0, fault=0. rst overrides every other input on every cycle.
- pll_locked passes through a 2-flop synchronizer; locked_s lags pll_locked by 2 cycles.
- All outputs are registered and decoded from next-state, so they change on the same edge as the state register.
- pll_rst=1 in PLL_RST and FAULT. sys_rst=0 only in RUN. ready=(state==RUN). fault=(state==FAULT).
- PLL_RST:
  - counter increments each cycle.
  - At counter==RST_PULSE_CYCLES-1: go to WAIT_LOCK, counter=0.
  - pll_rst is therefore high for exactly RST_PULSE_CYCLES cycles.
- WAIT_LOCK:
  - counter increments each cycle.
  - locked_s=1: go to STABILIZE, counter=0. This has priority over timeout in the same cycle.
  - Otherwise at counter==LOCK_TIMEOUT-1: the attempt fails.
- STABILIZE:
  - locked_s=0 in any cycle: the attempt fails (glitch counts as a failure, so retries stay bounded).
  - At counter==LOCK_STABLE_CYCLES-1 with locked_s=1: go to RUN, retry_cnt=0.
  - sys_rst release therefore occurs exactly 3+LOCK_STABLE_CYCLES cycles after a clean pll_locked rise.
- Attempt failure:
  - If retry_cnt==MAX_RETRIES: go to FAULT.
  - Else: retry_cnt++, go to PLL_RST, counter=0.
- RUN:
  - locked_s=0: go to PLL_RST, counter=0; retry_cnt is unchanged (stays 0).
  - sys_rst=1 and ready=0 take effect 3 cycles after pll_locked falls.
- FAULT:
  - Terminal. counter is held.
  - clear_fault=1: go to PLL_RST, retry_cnt=0, counter=0.
  - clear_fault is ignored in every other state.
- Counter never wraps: each state exits exactly at its terminal count.

Optional Feature:
PLL_SUP_LOSS_COUNT_EN:
- Defined: adds output loss_cnt[15:0], a count of RUN->PLL_RST transitions. It saturates at 16'hFFFF, is cleared only by rst, and is registered with the state update.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
(Parameters for all scenarios: RST_PULSE_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2.)
1. Clean bring-up: release rst; raise pll_locked 6 cycles after pll_rst falls -> pll_rst high exactly 4 cycles; sys_rst falls and ready rises exactly 11 cycles after the pll_locked rise; retry_cnt=0; fault=0.
2. Never locks: hold pll_locked=0 -> three 4-cycle pll_rst pulses, each 20 cycles apart; retry_cnt goes 1 then 2; after the third timeout fault=1, pll_rst=1 held, sys_rst=1.
3. Clear fault: from scenario 2, pulse clear_fault for 1 cycle, then apply a clean lock -> fault=0, retry_cnt=0, new 4-cycle pll_rst pulse, RUN reached as in scenario 1. clear_fault pulsed during RUN has no effect.
4. Lock loss in RUN: drop pll_locked for 1 cycle -> sys_rst=1 and ready=0 exactly 3 cycles later; 4-cycle pll_rst pulse follows; retry_cnt stays 0; loss_cnt=1 when PLL_SUP_LOSS_COUNT_EN is defined.
5. Glitch in STABILIZE: pll_locked=0 for 1 cycle 5 cycles into STABILIZE -> return to PLL_RST, retry_cnt=1, sys_rst never falls.
6. Reset mid-STABILIZE: assert rst for 1 cycle -> next cycle all outputs at reset values, retry_cnt=0, fresh 4-cycle pll_rst pulse after release.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock sequencer for the UART baud-clock PLL, clocked on refclk.
// Pulses the PLL reset, waits for a synchronized lock, requires the lock to
// stay continuously high before releasing the serial-port reset, and retries
// a bounded number of times before parking in FAULT.
// Optional build macro PLL_SUP_LOSS_COUNT_EN adds loss_cnt, a saturating
// count of lock losses seen while running.
module pll_lock_supervisor #(
  parameter int RST_PULSE_CYCLES   = 16,
  parameter int LOCK_TIMEOUT       = 50000,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES        = 3,
  parameter int CNT_W              = 20,
  parameter int RETRY_W            = 2
) (
  input  logic               refclk,
  input  logic               rst,
  input  logic               pll_locked,
  input  logic               clear_fault,
  output logic               pll_rst,
  output logic               sys_rst,
  output logic               ready,
  output logic               fault,
  output logic [RETRY_W-1:0] retry_cnt
`ifdef PLL_SUP_LOSS_COUNT_EN
  ,
  output logic [15:0]        loss_cnt
`endif
);

  typedef enum logic [2:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_STABILIZE,
    S_RUN,
    S_FAULT
  } state_t;

  localparam logic [CNT_W-1:0]   RST_LAST  = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STB_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               sync1_q, sync2_q;
  logic               locked_s;
  logic               attempt_fail;
  logic               pll_rst_q, sys_rst_q, ready_q, fault_q;

  assign locked_s = sync2_q;

  // Two-flop synchronizer for the asynchronous PLL lock indication.
  always_ff @(posedge refclk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pll_locked;
      sync2_q <= sync1_q;
    end
  end

  // Next-state, shared counter and retry bookkeeping.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    retry_d      = retry_q;
    attempt_fail = 1'b0;
    case (state_q)
      S_PLL_RST: begin
        if (cnt_q == RST_LAST) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_LOCK: begin
        // A lock seen on the timeout cycle still counts as a lock.
        if (locked_s) begin
          state_d = S_STABILIZE;
          cnt_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          attempt_fail = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STABILIZE: begin
        // Any dropout restarts the whole attempt so retries stay bounded.
        if (!locked_s) begin
          attempt_fail = 1'b1;
        end else if (cnt_q == STB_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
          retry_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        if (!locked_s) begin
          state_d = S_PLL_RST;
          cnt_d   = '0;
        end
      end
      S_FAULT: begin
        if (clear_fault) begin
          state_d = S_PLL_RST;
          cnt_d   = '0;
          retry_d = '0;
        end
      end
      default: begin
        state_d = S_PLL_RST;
        cnt_d   = '0;
      end
    endcase
    if (attempt_fail) begin
      if (retry_q == RETRY_MAX) begin
        state_d = S_FAULT;
      end else begin
        retry_d = retry_q + 1'b1;
        state_d = S_PLL_RST;
        cnt_d   = '0;
      end
    end
  end

  // State register with outputs decoded from next state so they move together.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q   <= S_PLL_RST;
      cnt_q     <= '0;
      retry_q   <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      pll_rst_q <= (state_d == S_PLL_RST) || (state_d == S_FAULT);
      sys_rst_q <= (state_d != S_RUN);
      ready_q   <= (state_d == S_RUN);
      fault_q   <= (state_d == S_FAULT);
    end
  end

  assign pll_rst   = pll_rst_q;
  assign sys_rst   = sys_rst_q;
  assign ready     = ready_q;
  assign fault     = fault_q;
  assign retry_cnt = retry_q;

`ifdef PLL_SUP_LOSS_COUNT_EN
  logic [15:0] loss_q, loss_d;

  // Saturating count of lock losses while running.
  always_comb begin
    loss_d = loss_q;
    if ((state_q == S_RUN) && (state_d == S_PLL_RST) && (loss_q != 16'hFFFF))
      loss_d = loss_q + 16'd1;
  end

  // Loss counter register, cleared only by rst.
  always_ff @(posedge refclk) begin
    if (rst) loss_q <= '0;
    else     loss_q <= loss_d;
  end

  assign loss_cnt = loss_q;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: a hand-derived vector table, two
// multi-cycle corner sequences, and a random run, all cross-checked each
// cycle against a phase/elapsed-time reference model.
module tb_pll_lock_supervisor;
  localparam int RP   = 4;
  localparam int TO   = 20;
  localparam int ST   = 8;
  localparam int MAXR = 2;

  localparam int PH_RST = 0, PH_WAIT = 1, PH_STAB = 2, PH_RUN = 3, PH_FAULT = 4;

  logic refclk = 1'b0;
  logic rst = 1'b1, pll_locked = 1'b0, clear_fault = 1'b0;
  logic pll_rst, sys_rst, ready, fault;
  logic [1:0] retry_cnt;
`ifdef PLL_SUP_LOSS_COUNT_EN
  logic [15:0] loss_cnt;
`endif

  pll_lock_supervisor #(
    .RST_PULSE_CYCLES(RP), .LOCK_TIMEOUT(TO), .LOCK_STABLE_CYCLES(ST),
    .MAX_RETRIES(MAXR), .CNT_W(20), .RETRY_W(2)
  ) dut (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .clear_fault(clear_fault),
    .pll_rst(pll_rst), .sys_rst(sys_rst), .ready(ready), .fault(fault),
    .retry_cnt(retry_cnt)
`ifdef PLL_SUP_LOSS_COUNT_EN
    , .loss_cnt(loss_cnt)
`endif
  );

  always #5 refclk = ~refclk;

  int nchk = 0, nerr = 0;

  // reference model: phase plus the cycle at which the phase began
  int cyc = 0, ph_start = 0, m_ph = PH_RST, m_rc = 0, m_loss = 0;
  int sd0 = 0, sd1 = 0;

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s @cyc %0d: got 'h%0h expected 'h%0h", name, cyc, act, exp);
    end
  endtask

  task automatic enter(input int ph);
    m_ph = ph;
    ph_start = cyc + 1;
  endtask

  task automatic step();
    int ls, el;
    bit fail;
    logic [5:0] e, a;
    @(posedge refclk);
    ls = sd1;
    el = cyc - ph_start;
    fail = 0;
    if (rst) begin
      enter(PH_RST);
      m_rc = 0; m_loss = 0; sd0 = 0; sd1 = 0;
    end else begin
      case (m_ph)
        PH_RST:   if (el == RP - 1) enter(PH_WAIT);
        PH_WAIT:  if (ls != 0) enter(PH_STAB); else if (el == TO - 1) fail = 1;
        PH_STAB:  if (ls == 0) fail = 1; else if (el == ST - 1) begin enter(PH_RUN); m_rc = 0; end
        PH_RUN:   if (ls == 0) begin enter(PH_RST); if (m_loss < 65535) m_loss++; end
        PH_FAULT: if (clear_fault) begin enter(PH_RST); m_rc = 0; end
        default:  ;
      endcase
      if (fail) begin
        if (m_rc == MAXR) enter(PH_FAULT);
        else begin m_rc++; enter(PH_RST); end
      end
      sd1 = sd0;
      sd0 = int'(pll_locked);
    end
    cyc++;
    #1;
    e = {(m_ph == PH_RST) || (m_ph == PH_FAULT), m_ph != PH_RUN, m_ph == PH_RUN,
         m_ph == PH_FAULT, 2'(m_rc)};
    a = {pll_rst, sys_rst, ready, fault, retry_cnt};
    chk("model", int'(a), int'(e));
`ifdef PLL_SUP_LOSS_COUNT_EN
    chk("model_loss", int'(loss_cnt), m_loss);
`endif
  endtask

  typedef struct {
    logic r, lk, clr;
    int   n;
    logic pr, sr, rdy, flt;
    logic [1:0] rc;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, lk, clr, input int n,
                     input logic pr, sr, rdy, flt, input logic [1:0] rc);
    vec_t v;
    v.r = r; v.lk = lk; v.clr = clr; v.n = n;
    v.pr = pr; v.sr = sr; v.rdy = rdy; v.flt = flt; v.rc = rc;
    tbl.push_back(v);
  endtask

  initial begin
    logic [5:0] ev, av;
    int pr_hi, seg;
    bit sr_fell;

    // never locks: three attempts then FAULT
    add(1,0,0, 1, 1,1,0,0,0);
    add(0,0,0, 3, 1,1,0,0,0);
    add(0,0,0, 1, 0,1,0,0,0);
    add(0,0,0,19, 0,1,0,0,0);
    add(0,0,0, 1, 1,1,0,0,1);
    add(0,0,0, 3, 1,1,0,0,1);
    add(0,0,0, 1, 0,1,0,0,1);
    add(0,0,0,19, 0,1,0,0,1);
    add(0,0,0, 1, 1,1,0,0,2);
    add(0,0,0, 3, 1,1,0,0,2);
    add(0,0,0, 1, 0,1,0,0,2);
    add(0,0,0,19, 0,1,0,0,2);
    add(0,0,0, 1, 1,1,0,1,2);
    add(0,0,0,10, 1,1,0,1,2);
    // clear fault, then a clean lock
    add(0,0,1, 1, 1,1,0,0,0);
    add(0,1,0, 3, 1,1,0,0,0);
    add(0,1,0, 1, 0,1,0,0,0);
    add(0,1,0, 8, 0,1,0,0,0);
    add(0,1,0, 1, 0,0,1,0,0);
    // clear_fault in RUN is ignored
    add(0,1,1, 1, 0,0,1,0,0);
    // one-cycle lock loss in RUN
    add(0,0,0, 1, 0,0,1,0,0);
    add(0,1,0, 1, 0,0,1,0,0);
    add(0,1,0, 1, 1,1,0,0,0);
    add(0,1,0, 3, 1,1,0,0,0);
    add(0,1,0, 1, 0,1,0,0,0);
    add(0,1,0, 8, 0,1,0,0,0);
    add(0,1,0, 1, 0,0,1,0,0);
    // clean bring-up: lock 6 cycles after pll_rst falls, RUN 11 cycles later
    add(1,0,0, 1, 1,1,0,0,0);
    add(0,0,0, 3, 1,1,0,0,0);
    add(0,0,0, 1, 0,1,0,0,0);
    add(0,0,0, 5, 0,1,0,0,0);
    add(0,1,0,10, 0,1,0,0,0);
    add(0,1,0, 1, 0,0,1,0,0);

    #2;
    foreach (tbl[i]) begin
      rst = tbl[i].r; pll_locked = tbl[i].lk; clear_fault = tbl[i].clr;
      repeat (tbl[i].n) step();
      ev = {tbl[i].pr, tbl[i].sr, tbl[i].rdy, tbl[i].flt, tbl[i].rc};
      av = {pll_rst, sys_rst, ready, fault, retry_cnt};
      chk($sformatf("vec%0d", i), int'(av), int'(ev));
    end
    clear_fault = 0;

    // glitch five cycles into STABILIZE
    rst = 1; step(); rst = 0; pll_locked = 1;
    sr_fell = 0;
    repeat (RP + 1 + 5) begin step(); if (!sys_rst) sr_fell = 1; end
    pll_locked = 0; step(); if (!sys_rst) sr_fell = 1;
    pll_locked = 1;
    repeat (2) begin step(); if (!sys_rst) sr_fell = 1; end
    chk("glitch_no_release", int'(sr_fell), 0);
    chk("glitch_retry", int'(retry_cnt), 1);
    chk("glitch_pll_rst", int'(pll_rst), 1);

    // reset mid-STABILIZE
    repeat (RP + 1 + 3) step();
    chk("pre_rst_retry", int'(retry_cnt), 1);
    chk("pre_rst_sys_rst", int'(sys_rst), 1);
    rst = 1; step(); rst = 0;
    chk("rst_outputs", int'({pll_rst, sys_rst, ready, fault, retry_cnt}), 'b110000);
    pr_hi = 1;
    for (int k = 0; k < 10; k++) begin
      step();
      if (!pll_rst) break;
      pr_hi++;
    end
    chk("rst_pulse_len", pr_hi, RP);

    // random run against the model
    seg = 0;
    for (int k = 0; k < 4000; k++) begin
      if (seg == 0) begin
        pll_locked = 1'($urandom_range(0, 1));
        seg = $urandom_range(1, 40);
      end
      seg--;
      rst = ($urandom_range(0, 299) == 0);
      clear_fault = ($urandom_range(0, 19) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
